// File: rtl/mld_cyclic_shift_register.sv
// Cyclic shift register for the Type-I majority-logic decoder.
// Holds one codeword and supports parallel load, serial shift-in and
// rotation with a correction bit XORed into the recirculated LSB.
// A modulo-N shift counter pulses done once per N shift/rotate edges.
module mld_cyclic_shift_register #(
   parameter int N  = 7,
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic [1:0]    mode,
   input  logic [N-1:0]  load_data,
   input  logic          serial_in,
   input  logic          corr_in,
   output logic [N-1:0]  q,
   output logic          serial_out,
   output logic [CW-1:0] shift_cnt,
   output logic          done
);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_LOAD  = 2'b01;
   localparam logic [1:0] MODE_SHIFT = 2'b10;
   localparam logic [1:0] MODE_ROT   = 2'b11;

   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   logic [N-1:0]  q_nxt;
   logic [CW-1:0] cnt_nxt;
   logic          done_nxt;
   logic          cnt_wrap;

   // Counter only ever steps 0..N-1, so unused codes stay unreachable.
   assign cnt_wrap   = (shift_cnt == CNT_LAST);
   assign serial_out = q[0];

   // Next-state selection by mode; done defaults low so it is a pulse.
   always_comb begin
      q_nxt    = q;
      cnt_nxt  = shift_cnt;
      done_nxt = 1'b0;
      if (en) begin
         case (mode)
            MODE_HOLD: ;
            MODE_LOAD: begin
               q_nxt   = load_data;
               cnt_nxt = '0;
            end
            MODE_SHIFT, MODE_ROT: begin
               if (mode == MODE_SHIFT)
                  q_nxt = {serial_in, q[N-1:1]};
               else
                  q_nxt = {q[0] ^ corr_in, q[N-1:1]};
               if (cnt_wrap) begin
                  cnt_nxt  = '0;
                  done_nxt = 1'b1;
               end else begin
                  cnt_nxt  = shift_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q         <= '0;
         shift_cnt <= '0;
         done      <= 1'b0;
      end else begin
         q         <= q_nxt;
         shift_cnt <= cnt_nxt;
         done      <= done_nxt;
      end
   end

endmodule

// File: tb/tb_mld_cyclic_shift_register.sv
// Directed bench for mld_cyclic_shift_register (N=7, CW=3).
module tb_mld_cyclic_shift_register;

   localparam int N  = 7;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          en;
   logic [1:0]    mode;
   logic [N-1:0]  load_data;
   logic          serial_in;
   logic          corr_in;
   logic [N-1:0]  q;
   logic          serial_out;
   logic [CW-1:0] shift_cnt;
   logic          done;

   int n_cmp = 0;
   int n_err = 0;

   mld_cyclic_shift_register #(.N(N), .CW(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .mode       (mode),
      .load_data  (load_data),
      .serial_in  (serial_in),
      .corr_in    (corr_in),
      .q          (q),
      .serial_out (serial_out),
      .shift_cnt  (shift_cnt),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle so outputs are sampled away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [N-1:0] d);
      en = 1'b1; mode = 2'b01; load_data = d;
      step();
   endtask

   // Right rotations of 1011001 with corr_in=0, edges 1..7.
   logic [N-1:0] rot_tbl [7] = '{7'b1101100, 7'b0110110, 7'b0011011, 7'b1001101,
                                 7'b1100110, 7'b0110011, 7'b1011001};
   logic [6:0]   fill_seq = 7'b0001101; // bit i is serial_in on edge i+1

   initial begin
      reset = 1'b0; en = 1'b0; mode = 2'b00; load_data = '0;
      serial_in = 1'b0; corr_in = 1'b0;
      #12;
      chk("rst_q", q, 0);
      chk("rst_cnt", shift_cnt, 0);
      chk("rst_done", done, 0);
      reset = 1'b1;

      // Async reset between edges from an all-ones register.
      do_load(7'b1111111);
      chk("ones_q", q, 7'h7f);
      #2 reset = 1'b0;
      #1;
      chk("async_q", q, 0);
      chk("async_cnt", shift_cnt, 0);
      chk("async_done", done, 0);
      step(); step();
      chk("rst_hold_q", q, 0);
      chk("rst_hold_cnt", shift_cnt, 0);
      reset = 1'b1;

      // Load.
      do_load(7'b1011001);
      chk("load_q", q, 7'b1011001);
      chk("load_sout", serial_out, 1);
      chk("load_cnt", shift_cnt, 0);
      chk("load_done", done, 0);

      // Full rotation.
      mode = 2'b11; corr_in = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         step();
         chk($sformatf("rot_q%0d", i), q, rot_tbl[i-1]);
         chk($sformatf("rot_cnt%0d", i), shift_cnt, i % 7);
         chk($sformatf("rot_done%0d", i), done, (i == 7) ? 1 : 0);
      end
      mode = 2'b00;
      step();
      chk("hold_done", done, 0);
      chk("hold_q", q, 7'b1011001);
      chk("hold_cnt", shift_cnt, 0);

      // Correction on the recirculated bit.
      do_load(7'b1011001);
      mode = 2'b11; corr_in = 1'b1;
      step();
      chk("corr_q", q, 7'b0101100);
      chk("corr_cnt", shift_cnt, 1);
      corr_in = 1'b0;

      // Serial fill.
      do_load(7'b0000000);
      mode = 2'b10;
      for (int i = 0; i < 7; i++) begin
         serial_in = fill_seq[i];
         step();
         chk($sformatf("fill_done%0d", i + 1), done, (i == 6) ? 1 : 0);
      end
      chk("fill_q", q, 7'b0001101);
      chk("fill_cnt", shift_cnt, 0);

      // Back-to-back cycle gives the next pulse exactly N edges later.
      mode = 2'b11;
      for (int i = 1; i <= 7; i++) begin
         step();
         chk($sformatf("cyc2_done%0d", i), done, (i == 7) ? 1 : 0);
      end
      chk("cyc2_q", q, 7'b0001101);

      // Mixed shift/rotate modes share the counter.
      do_load(7'b1011001);
      for (int i = 1; i <= 7; i++) begin
         mode = (i % 2 == 1) ? 2'b10 : 2'b11;
         serial_in = 1'b1;
         step();
         chk($sformatf("mix_cnt%0d", i), shift_cnt, i % 7);
         chk($sformatf("mix_done%0d", i), done, (i == 7) ? 1 : 0);
      end

      // Load mid-cycle restarts the count and suppresses the pulse.
      do_load(7'b1011001);
      mode = 2'b11;
      for (int i = 0; i < 5; i++) step();
      do_load(7'b1011001);
      chk("reload_cnt", shift_cnt, 0);
      mode = 2'b11;
      for (int i = 0; i < 6; i++) step();
      chk("reload_cnt6", shift_cnt, 6);
      chk("reload_nodone", done, 0);
      step();
      chk("reload_done", done, 1);
      en = 1'b0;
      step();
      chk("en0_done_clr", done, 0);

      // Enable hold, then reset mid-operation.
      do_load(7'b1011001);
      mode = 2'b11;
      for (int i = 0; i < 3; i++) step();
      chk("rot3_q", q, 7'b0011011);
      chk("rot3_cnt", shift_cnt, 3);
      en = 1'b0;
      step(); step();
      chk("en0_q", q, 7'b0011011);
      chk("en0_cnt", shift_cnt, 3);
      chk("en0_done", done, 0);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_q", q, 0);
      chk("mid_rst_cnt", shift_cnt, 0);
      #3 reset = 1'b1;
      #1;
      do_load(7'b1011001);
      chk("post_rst_cnt0", shift_cnt, 0);
      mode = 2'b11;
      step();
      chk("post_rst_cnt1", shift_cnt, 1);
      chk("post_rst_q", q, 7'b1101100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Watchdog in case the stimulus ever stalls.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
